// File: rtl/iic_slave_regs.sv
// I2C target emulating an MPU-6050-style 128x8 register file, with a local update port
// so fabric logic can refresh the sensor registers.
module iic_slave_regs #(
  parameter logic [6:0] DEV_ADDR     = 7'h68,
  parameter int         SYNC_STAGES  = 2,
  parameter logic [7:0] WHO_AM_I_VAL = 8'h68
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  input  logic       upd_we,
  input  logic [6:0] upd_addr,
  input  logic [7:0] upd_data,
  output logic       wr_valid,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  localparam logic [6:0] WHOAMI_IDX = 7'h75;
  localparam logic [6:0] PWR_IDX    = 7'h6B;

  typedef enum logic [2:0] {
    ST_IDLE, ST_DEVADDR, ST_REGPTR, ST_WRDATA, ST_RDDATA, ST_RDACK, ST_IGNORE
  } state_t;

  state_t                 state_r, state_n;
  logic [SYNC_STAGES-1:0] scl_sync_r, sda_sync_r;
  logic                   scl_d_r, sda_d_r;
  logic                   scl_s, sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;
  logic [3:0]             bitcnt_r, bitcnt_n;
  logic [7:0]             shift_in_r, shift_in_n, shift_out_r, shift_out_n;
  logic [6:0]             ptr_r, ptr_n;
  logic                   sda_oe_r, sda_oe_n, busy_r, busy_n;
  logic                   wr_valid_r, wr_valid_n;
  logic [6:0]             wr_addr_r, wr_addr_n;
  logic [7:0]             wr_data_r, wr_data_n;
  logic                   i2c_we_s;
  logic [7:0]             rx_byte_s, reg_rd_s;
  logic [7:0]             regs_r [0:127];

  assign sda      = sda_oe_r ? 1'b0 : 1'bz;
  assign wr_valid = wr_valid_r;
  assign wr_addr  = wr_addr_r;
  assign wr_data  = wr_data_r;
  assign busy     = busy_r;

  assign scl_s      = scl_sync_r[SYNC_STAGES-1];
  assign sda_s      = sda_sync_r[SYNC_STAGES-1];
  assign scl_rise_s = scl_s & ~scl_d_r;
  assign scl_fall_s = ~scl_s & scl_d_r;
  assign start_s    = scl_s & scl_d_r & sda_d_r & ~sda_s;
  assign stop_s     = scl_s & scl_d_r & ~sda_d_r & sda_s;
  assign rx_byte_s  = {shift_in_r[6:0], sda_s};
  assign reg_rd_s   = regs_r[ptr_r];

  // Bus synchronizers and edge-detect history; idle bus level is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_r <= {SYNC_STAGES{1'b1}};
      sda_sync_r <= {SYNC_STAGES{1'b1}};
      scl_d_r    <= 1'b1;
      sda_d_r    <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl};
      sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda};
      scl_d_r    <= scl_s;
      sda_d_r    <= sda_s;
    end
  end

  // FSM state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      bitcnt_r    <= 4'd0;
      shift_in_r  <= 8'h00;
      shift_out_r <= 8'h00;
      ptr_r       <= 7'h00;
      sda_oe_r    <= 1'b0;
      busy_r      <= 1'b0;
      wr_valid_r  <= 1'b0;
      wr_addr_r   <= 7'h00;
      wr_data_r   <= 8'h00;
    end else begin
      state_r     <= state_n;
      bitcnt_r    <= bitcnt_n;
      shift_in_r  <= shift_in_n;
      shift_out_r <= shift_out_n;
      ptr_r       <= ptr_n;
      sda_oe_r    <= sda_oe_n;
      busy_r      <= busy_n;
      wr_valid_r  <= wr_valid_n;
      wr_addr_r   <= wr_addr_n;
      wr_data_r   <= wr_data_n;
    end
  end

  // Register file; the I2C write is issued last so it wins an address collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 128; i++) regs_r[i] <= 8'h00;
      regs_r[PWR_IDX]    <= 8'h40;
      regs_r[WHOAMI_IDX] <= WHO_AM_I_VAL;
    end else begin
      if (upd_we && (upd_addr != WHOAMI_IDX)) regs_r[upd_addr] <= upd_data;
      if (i2c_we_s) regs_r[ptr_r] <= rx_byte_s;
    end
  end

  // Next-state logic: bits sampled on scl rise, sda drive changed only on scl fall.
  // bitcnt 8 marks the ACK slot, 9 means the ACK clock has risen.
  always_comb begin
    state_n     = state_r;
    bitcnt_n    = bitcnt_r;
    shift_in_n  = shift_in_r;
    shift_out_n = shift_out_r;
    ptr_n       = ptr_r;
    sda_oe_n    = sda_oe_r;
    busy_n      = busy_r;
    wr_valid_n  = 1'b0;
    wr_addr_n   = wr_addr_r;
    wr_data_n   = wr_data_r;
    i2c_we_s    = 1'b0;
    if (start_s) begin
      state_n  = ST_DEVADDR;
      bitcnt_n = 4'd0;
      sda_oe_n = 1'b0;
    end else if (stop_s) begin
      state_n  = ST_IDLE;
      bitcnt_n = 4'd0;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else if (scl_rise_s) begin
      case (state_r)
        ST_DEVADDR, ST_REGPTR, ST_WRDATA: begin
          if (bitcnt_r < 4'd8) begin
            shift_in_n = rx_byte_s;
            bitcnt_n   = bitcnt_r + 4'd1;
            if (bitcnt_r == 4'd7) begin
              case (state_r)
                ST_DEVADDR: begin
                  if (rx_byte_s[7:1] == DEV_ADDR) busy_n = 1'b1;
                  else state_n = ST_IGNORE;
                end
                ST_REGPTR: ptr_n = rx_byte_s[6:0];
                ST_WRDATA: begin
                  if (ptr_r != WHOAMI_IDX) begin
                    i2c_we_s   = 1'b1;
                    wr_valid_n = 1'b1;
                    wr_addr_n  = ptr_r;
                    wr_data_n  = rx_byte_s;
                  end else begin
                    i2c_we_s   = 1'b0;
                  end
                  ptr_n = ptr_r + 7'd1;
                end
                default: ptr_n = ptr_r;
              endcase
            end else begin
              ptr_n = ptr_r;
            end
          end else if (bitcnt_r == 4'd8) begin
            bitcnt_n = 4'd9;
          end else begin
            bitcnt_n = bitcnt_r;
          end
        end
        ST_RDDATA: begin
          if (bitcnt_r < 4'd8) bitcnt_n = bitcnt_r + 4'd1;
          else bitcnt_n = bitcnt_r;
        end
        ST_RDACK: begin
          if (bitcnt_r == 4'd8) begin
            if (!sda_s) begin
              ptr_n    = ptr_r + 7'd1;
              bitcnt_n = 4'd9;
            end else begin
              busy_n  = 1'b0;
              state_n = ST_IGNORE;
            end
          end else begin
            bitcnt_n = bitcnt_r;
          end
        end
        default: state_n = state_r;
      endcase
    end else if (scl_fall_s) begin
      case (state_r)
        ST_DEVADDR, ST_REGPTR, ST_WRDATA: begin
          if (bitcnt_r == 4'd8) begin
            sda_oe_n = 1'b1;
          end else if (bitcnt_r == 4'd9) begin
            bitcnt_n = 4'd0;
            sda_oe_n = 1'b0;
            case (state_r)
              ST_DEVADDR: begin
                if (shift_in_r[0]) begin
                  state_n     = ST_RDDATA;
                  shift_out_n = reg_rd_s;
                  sda_oe_n    = ~reg_rd_s[7];
                end else begin
                  state_n     = ST_REGPTR;
                end
              end
              ST_REGPTR: state_n = ST_WRDATA;
              default:   state_n = state_r;
            endcase
          end else begin
            sda_oe_n = sda_oe_r;
          end
        end
        ST_RDDATA: begin
          if (bitcnt_r == 4'd8) begin
            sda_oe_n = 1'b0;
            state_n  = ST_RDACK;
          end else if (bitcnt_r != 4'd0) begin
            shift_out_n = {shift_out_r[6:0], 1'b0};
            sda_oe_n    = ~shift_out_r[6];
          end else begin
            sda_oe_n = sda_oe_r;
          end
        end
        ST_RDACK: begin
          if (bitcnt_r == 4'd9) begin
            shift_out_n = reg_rd_s;
            sda_oe_n    = ~reg_rd_s[7];
            bitcnt_n    = 4'd0;
            state_n     = ST_RDDATA;
          end else begin
            sda_oe_n = sda_oe_r;
          end
        end
        default: state_n = state_r;
      endcase
    end else begin
      state_n = state_r;
    end
  end

endmodule

// File: tb/tb_iic_slave_regs.sv
// Directed bench for iic_slave_regs: bit-banged I2C master with hand-computed expectations.
`timescale 1ns/1ps
module tb_iic_slave_regs;

  localparam int Q = 100;

  logic       clk = 1'b0, rst_n = 1'b0, scl = 1'b1, m_oe = 1'b0;
  logic       upd_we = 1'b0;
  logic [6:0] upd_addr = 7'h00;
  logic [7:0] upd_data = 8'h00;
  logic       wr_valid, busy;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  wire        sda;

  int errors = 0, checks = 0, wr_cnt = 0;
  logic [6:0] last_wa = 7'h00;
  logic [7:0] last_wd = 8'h00;

  assign sda = m_oe ? 1'b0 : 1'bz;
  pullup (sda);

  iic_slave_regs dut (
    .clk(clk), .rst_n(rst_n), .scl(scl), .sda(sda),
    .upd_we(upd_we), .upd_addr(upd_addr), .upd_data(upd_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_valid === 1'b1) begin
      wr_cnt  = wr_cnt + 1;
      last_wa = wr_addr;
      last_wd = wr_data;
    end
  end

  task automatic i2c_start;
    m_oe = 1'b1; #Q; scl = 1'b0; #Q;
  endtask

  task automatic i2c_rstart;
    m_oe = 1'b0; #Q; scl = 1'b1; #Q; m_oe = 1'b1; #Q; scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop;
    m_oe = 1'b1; #Q; scl = 1'b1; #Q; m_oe = 1'b0; #Q;
  endtask

  task automatic put_bit(input logic b);
    m_oe = ~b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
  endtask

  task automatic get_bit(output logic b);
    m_oe = 1'b0; #Q; scl = 1'b1; #Q; b = sda; #Q; scl = 1'b0; #Q;
  endtask

  task automatic put_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(b);
    ack = ~b;
  endtask

  task automatic get_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(~ack);
  endtask

  task automatic rd_reg(input logic [6:0] a, output logic [7:0] d, output logic ok);
    logic a1, a2, a3;
    i2c_start;
    put_byte(8'hD0, a1);
    put_byte({1'b0, a}, a2);
    i2c_rstart;
    put_byte(8'hD1, a3);
    get_byte(d, 1'b0);
    i2c_stop;
    ok = a1 & a2 & a3;
  endtask

  task automatic wr_reg(input logic [6:0] a, input logic [7:0] v, output logic ok);
    logic a1, a2, a3;
    i2c_start;
    put_byte(8'hD0, a1);
    put_byte({1'b0, a}, a2);
    put_byte(v, a3);
    i2c_stop;
    ok = a1 & a2 & a3;
  endtask

  task automatic cur_rd(output logic [7:0] d, output logic ok);
    i2c_start;
    put_byte(8'hD1, ok);
    get_byte(d, 1'b0);
    i2c_stop;
  endtask

  task automatic local_upd(input logic [6:0] a, input logic [7:0] v);
    @(negedge clk);
    upd_we = 1'b1; upd_addr = a; upd_data = v;
    @(negedge clk);
    upd_we = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    logic ok;
    repeat (5) @(negedge clk);
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL reset_sda: got %b expected 1", sda); end
    checks++; if ({busy, wr_valid} !== 2'b00) begin errors++; $display("FAIL reset_flags: got busy=%b wr_valid=%b expected 0 0", busy, wr_valid); end
    checks++; if ({wr_addr, wr_data} !== 15'h0000) begin errors++; $display("FAIL reset_wr: got %h/%h expected 00/00", wr_addr, wr_data); end
    rst_n = 1'b1;
    #Q;
    rd_reg(7'h75, d, ok);
    checks++; if (ok !== 1'b1 || d !== 8'h68) begin errors++; $display("FAIL whoami: got %h ack=%b expected 68 ack=1", d, ok); end
    rd_reg(7'h6B, d, ok);
    checks++; if (ok !== 1'b1 || d !== 8'h40) begin errors++; $display("FAIL pwr_reset: got %h ack=%b expected 40 ack=1", d, ok); end
  endtask

  task automatic test_write;
    logic [7:0] d;
    logic ok;
    int n;
    n = wr_cnt;
    wr_reg(7'h6B, 8'h00, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL write_ack: got %b expected 1", ok); end
    checks++; if (wr_cnt - n != 1 || last_wa !== 7'h6B || last_wd !== 8'h00) begin
      errors++; $display("FAIL write_pulse: got n=%0d %h/%h expected n=1 6b/00", wr_cnt - n, last_wa, last_wd); end
    rd_reg(7'h6B, d, ok);
    checks++; if (ok !== 1'b1 || d !== 8'h00) begin errors++; $display("FAIL write_readback: got %h expected 00", d); end
  endtask

  task automatic test_burst_read;
    logic [7:0] d;
    logic a1, a2, a3, ok;
    for (int i = 0; i < 14; i++) local_upd(7'h3B + 7'(i), 8'h10 + 8'(i));
    i2c_start;
    put_byte(8'hD0, a1);
    put_byte(8'h3B, a2);
    i2c_rstart;
    put_byte(8'hD1, a3);
    checks++; if ((a1 & a2 & a3) !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL burst_setup: got ack=%b busy=%b expected 1 1", a1 & a2 & a3, busy); end
    for (int i = 0; i < 14; i++) begin
      get_byte(d, i != 13);
      checks++; if (d !== 8'h10 + 8'(i)) begin errors++; $display("FAIL burst_byte%0d: got %h expected %h", i, d, 8'h10 + 8'(i)); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL burst_busy_nack: got %b expected 0", busy); end
    i2c_stop;
    cur_rd(d, ok);
    checks++; if (ok !== 1'b1 || d !== 8'h1D) begin errors++; $display("FAIL burst_ptr_reread: got %h expected 1d", d); end
  endtask

  task automatic test_mismatch;
    logic [7:0] d;
    logic a1, a2, a3, ok;
    int n;
    n = wr_cnt;
    i2c_start;
    put_byte(8'hA0, a1);
    checks++; if (a1 !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mismatch_ack: got ack=%b busy=%b expected 0 0", a1, busy); end
    put_byte(8'h10, a2);
    put_byte(8'h55, a3);
    i2c_stop;
    checks++; if ((a2 | a3) !== 1'b0 || wr_cnt != n) begin
      errors++; $display("FAIL mismatch_ignore: got acks=%b%b writes=%0d expected 00 0", a2, a3, wr_cnt - n); end
    rd_reg(7'h10, d, ok);
    checks++; if (ok !== 1'b1 || d !== 8'h00) begin errors++; $display("FAIL mismatch_reg: got %h expected 00", d); end
  endtask

  task automatic test_rstart;
    logic [7:0] d;
    logic ok;
    int n;
    rd_reg(7'h3F, d, ok);
    checks++; if (ok !== 1'b1 || d !== 8'h14) begin errors++; $display("FAIL rstart_read: got %h expected 14", d); end
    n = wr_cnt;
    wr_reg(7'h75, 8'h12, ok);
    checks++; if (ok !== 1'b1 || wr_cnt != n) begin errors++; $display("FAIL whoami_write: got ack=%b writes=%0d expected 1 0", ok, wr_cnt - n); end
    rd_reg(7'h75, d, ok);
    checks++; if (d !== 8'h68) begin errors++; $display("FAIL whoami_kept: got %h expected 68", d); end
  endtask

  task automatic test_abort_wrap;
    logic [7:0] d;
    logic a1, a2, a3, a4, ok;
    int n;
    local_upd(7'h30, 8'hA5);
    n = wr_cnt;
    i2c_start;
    put_byte(8'hD0, a1);
    put_byte(8'h30, a2);
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b1);
    i2c_stop;
    checks++; if (wr_cnt != n) begin errors++; $display("FAIL abort_nowrite: got %0d writes expected 0", wr_cnt - n); end
    cur_rd(d, ok);
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL abort_ptr: got %h expected a5", d); end
    n = wr_cnt;
    i2c_start;
    put_byte(8'hD0, a1);
    put_byte(8'h7F, a2);
    put_byte(8'h11, a3);
    put_byte(8'h22, a4);
    i2c_stop;
    checks++; if ((a1 & a2 & a3 & a4) !== 1'b1 || wr_cnt - n != 2 || last_wa !== 7'h00 || last_wd !== 8'h22) begin
      errors++; $display("FAIL wrap_write: got n=%0d %h/%h expected n=2 00/22", wr_cnt - n, last_wa, last_wd); end
    rd_reg(7'h7F, d, ok);
    checks++; if (d !== 8'h11) begin errors++; $display("FAIL wrap_7f: got %h expected 11", d); end
    rd_reg(7'h00, d, ok);
    checks++; if (d !== 8'h22) begin errors++; $display("FAIL wrap_00: got %h expected 22", d); end
  endtask

  task automatic test_collision;
    logic [7:0] d;
    logic a1, a2, a3, ok, seen;
    int n;
    n = wr_cnt;
    seen = 1'b0;
    i2c_start;
    put_byte(8'hD0, a1);
    put_byte(8'h20, a2);
    @(negedge clk);
    upd_we = 1'b1; upd_addr = 7'h20; upd_data = 8'h99;
    fork
      put_byte(8'h77, a3);
      begin
        for (int k = 0; k < 4000 && wr_valid !== 1'b1; k++) @(negedge clk);
        seen = (wr_valid === 1'b1);
        upd_we = 1'b0;
      end
    join
    i2c_stop;
    checks++; if (seen !== 1'b1 || wr_cnt - n != 1) begin errors++; $display("FAIL coll_pulse: got seen=%b n=%0d expected 1 1", seen, wr_cnt - n); end
    rd_reg(7'h20, d, ok);
    checks++; if ((a1 & a2 & a3 & ok) !== 1'b1 || d !== 8'h77) begin errors++; $display("FAIL coll_value: got %h expected 77", d); end
  endtask

  initial begin
    test_reset;
    test_write;
    test_burst_read;
    test_mismatch;
    test_rstart;
    test_abort_wrap;
    test_collision;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
